// File: rtl/ddma_pkg.sv
// Shared types and bit-index constants for the DDMA transmit engine.
package ddma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        RD   = 3'd3,
        WT   = 3'd4,
        SEND = 3'd5,
        DONE = 3'd6,
        ERR  = 3'd7
    } state_t;

    localparam int ST_BUSY  = 0;
    localparam int ST_DONE  = 1;
    localparam int ST_ERR   = 2;
    localparam int ST_OVR   = 3;

    localparam int IRQ_DONE = 0;
    localparam int IRQ_ERR  = 1;

endpackage

// File: rtl/ddma_serializer.sv
// Registered valid/ready flit output stage: carries either a single header flit
// or one memory word split into FPW flits, low slice first.
module ddma_serializer #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ld_flit,
    input  logic [FLIT_WIDTH-1:0]       ld_flit_data,
    input  logic                        ld_word,
    input  logic [MEMORY_BUS_WIDTH-1:0] ld_word_data,
    input  logic                        flit_ready,
    output logic [FLIT_WIDTH-1:0]       flit_out,
    output logic                        flit_valid,
    output logic                        accept,
    output logic                        last_accept
);

    localparam int FPW = MEMORY_BUS_WIDTH / FLIT_WIDTH;
    localparam int CW  = (FPW > 1) ? $clog2(FPW) : 1;

    logic [FLIT_WIDTH-1:0]       flit_r;
    logic                        valid_r;
    logic [MEMORY_BUS_WIDTH-1:0] buf_r;
    logic [CW-1:0]               cnt_r;

    assign flit_out    = flit_r;
    assign flit_valid  = valid_r;
    assign accept      = valid_r & flit_ready;
    // cnt_r counts flits still queued behind the one on the port
    assign last_accept = accept & (cnt_r == {CW{1'b0}});

    // Output register and shift buffer; a load takes priority over advancing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flit_r  <= {FLIT_WIDTH{1'b0}};
            valid_r <= 1'b0;
            buf_r   <= {MEMORY_BUS_WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (ld_word) begin
            flit_r  <= ld_word_data[FLIT_WIDTH-1:0];
            buf_r   <= ld_word_data >> FLIT_WIDTH;
            cnt_r   <= CW'(FPW - 1);
            valid_r <= 1'b1;
        end else if (ld_flit) begin
            flit_r  <= ld_flit_data;
            cnt_r   <= {CW{1'b0}};
            valid_r <= 1'b1;
        end else if (accept) begin
            if (cnt_r != {CW{1'b0}}) begin
                flit_r <= buf_r[FLIT_WIDTH-1:0];
                buf_r  <= buf_r >> FLIT_WIDTH;
                cnt_r  <= cnt_r - CW'(1);
            end else begin
                flit_r  <= {FLIT_WIDTH{1'b0}};
                valid_r <= 1'b0;
            end
        end else begin
            flit_r  <= flit_r;
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/ddma_tx_engine.sv
// DDMA responder: on a cmd_in rising edge, reads a block of local memory and
// streams it as header + payload flits to the NoC, reporting via status/irq.
module ddma_tx_engine
    import ddma_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int FLIT_WIDTH       = 16,
    parameter int ADDRESS          = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [MEMORY_BUS_WIDTH-3:0] addr_in,
    input  logic [MEMORY_BUS_WIDTH-3:0] nbytes_in,
    input  logic                        cmd_in,
    output logic [4:0]                  status_out,
    output logic [4:0]                  irq_out,
    output logic                        mem_en,
    output logic [MEMORY_BUS_WIDTH-3:0] mem_addr,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata,
    output logic [FLIT_WIDTH-1:0]       flit_out,
    output logic                        flit_valid,
    input  logic                        flit_ready
);

    localparam int AW  = MEMORY_BUS_WIDTH - 2;
    localparam int FPW = MEMORY_BUS_WIDTH / FLIT_WIDTH;
    localparam int BPW = MEMORY_BUS_WIDTH / 8;

    state_t          state_r, state_nxt_s;
    logic            cmd_q_r;
    logic [AW-1:0]   cur_addr_r, addr_nxt_s;
    logic [AW-1:0]   remaining_r, rem_nxt_s;
    logic [AW-1:0]   quot_s, rmd_s, words_s;
    logic [4:0]      status_r, irq_r;
    logic            mem_en_r;
    logic [AW-1:0]   mem_addr_r;
    logic            req_s, ovr_s;
    logic            ld_flit_s, ld_word_s;
    logic [FLIT_WIDTH-1:0] ld_flit_data_s;
    logic            accept_s, last_accept_s;

    assign status_out = status_r;
    assign irq_out    = irq_r;
    assign mem_en     = mem_en_r;
    assign mem_addr   = mem_addr_r;

    assign req_s   = cmd_in & ~cmd_q_r & (state_r == IDLE);
    assign ovr_s   = cmd_in & ~cmd_q_r & (state_r != IDLE);
    // Round up to whole words; the tail of the last word is don't-care.
    assign quot_s  = nbytes_in / AW'(BPW);
    assign rmd_s   = nbytes_in % AW'(BPW);
    assign words_s = quot_s + {{(AW-1){1'b0}}, (rmd_s != {AW{1'b0}})};

    ddma_serializer #(
        .MEMORY_BUS_WIDTH (MEMORY_BUS_WIDTH),
        .FLIT_WIDTH       (FLIT_WIDTH)
    ) u_ser (
        .clock        (clock),
        .reset        (reset),
        .ld_flit      (ld_flit_s),
        .ld_flit_data (ld_flit_data_s),
        .ld_word      (ld_word_s),
        .ld_word_data (mem_rdata),
        .flit_ready   (flit_ready),
        .flit_out     (flit_out),
        .flit_valid   (flit_valid),
        .accept       (accept_s),
        .last_accept  (last_accept_s)
    );

    // Next-state, serializer loads and address/word-count updates.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = cur_addr_r;
        rem_nxt_s      = remaining_r;
        ld_flit_s      = 1'b0;
        ld_flit_data_s = {FLIT_WIDTH{1'b0}};
        ld_word_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    addr_nxt_s = addr_in;
                    rem_nxt_s  = words_s;
                    if (nbytes_in == {AW{1'b0}}) begin
                        state_nxt_s = ERR;
                    end else begin
                        state_nxt_s    = HDR0;
                        ld_flit_s      = 1'b1;
                        ld_flit_data_s = FLIT_WIDTH'(ADDRESS);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HDR0: begin
                if (accept_s) begin
                    state_nxt_s    = HDR1;
                    ld_flit_s      = 1'b1;
                    ld_flit_data_s = FLIT_WIDTH'(remaining_r * AW'(FPW));
                end else begin
                    state_nxt_s = HDR0;
                end
            end
            HDR1: begin
                if (accept_s) begin
                    state_nxt_s = RD;
                end else begin
                    state_nxt_s = HDR1;
                end
            end
            RD:   state_nxt_s = WT;
            WT: begin
                ld_word_s   = 1'b1;
                state_nxt_s = SEND;
            end
            SEND: begin
                if (last_accept_s) begin
                    addr_nxt_s  = cur_addr_r + AW'(1);
                    rem_nxt_s   = remaining_r - AW'(1);
                    state_nxt_s = (remaining_r == AW'(1)) ? DONE : RD;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            DONE:    state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, counters and command edge register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cmd_q_r     <= 1'b0;
            cur_addr_r  <= {AW{1'b0}};
            remaining_r <= {AW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cmd_q_r     <= cmd_in;
            cur_addr_r  <= addr_nxt_s;
            remaining_r <= rem_nxt_s;
        end
    end

    // Registered memory port, status and irq, all decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_en_r   <= 1'b0;
            mem_addr_r <= {AW{1'b0}};
            status_r   <= 5'b00000;
            irq_r      <= 5'b00000;
        end else begin
            mem_en_r   <= (state_nxt_s == RD);
            mem_addr_r <= (state_nxt_s == RD) ? addr_nxt_s : {AW{1'b0}};
            status_r[ST_BUSY] <= (state_nxt_s != IDLE);
            status_r[ST_DONE] <= (state_nxt_s == DONE) | (status_r[ST_DONE] & ~req_s);
            status_r[ST_ERR]  <= (state_nxt_s == ERR)  | (status_r[ST_ERR]  & ~req_s);
            status_r[ST_OVR]  <= ovr_s | (status_r[ST_OVR] & ~req_s);
            status_r[4]       <= 1'b0;
            irq_r <= {3'b000, (state_nxt_s == ERR), (state_nxt_s == DONE)};
        end
    end

endmodule
